// File: rtl/ps2_scancode_queue.sv
// PS/2 scancode queue: folds F0 break prefixes into bit 7 and buffers
// the resulting keycodes in a small circular FIFO for a polled/irq consumer.
module ps2_scancode_queue #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       scancode_valid,
  input  logic       scancode_error,
  input  logic       read_ack,
  input  logic       clear_overflow,
  input  logic       irq_enable,
  output logic [7:0] keycode,
  output logic       keycode_valid,
  output logic       irq,
  output logic       overflow_flag,
  output logic [7:0] error_count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {
    IDLE,
    BREAK_PENDING
  } state_t;

  state_t state, state_next;

  logic       push;
  logic [7:0] push_data;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;

  logic full;
  logic empty;
  logic do_pop;
  logic do_push;
  logic drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (scancode_error) begin
      state_next = IDLE;
    end else if (scancode_valid) begin
      unique case (state)
        IDLE: begin
          if (scancode == 8'hF0) state_next = BREAK_PENDING;
        end
        BREAK_PENDING: begin
          if (scancode != 8'hF0 && scancode != 8'hE0)
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // E0 inside a pending break is passed through and keeps the break armed
  always_comb begin
    push      = 1'b0;
    push_data = scancode;
    if (scancode_valid && !scancode_error) begin
      unique case (state)
        IDLE: begin
          push = (scancode != 8'hF0);
        end
        BREAK_PENDING: begin
          push = (scancode != 8'hF0);
          if (scancode != 8'hE0) push_data = scancode | 8'h80;
        end
        default: push = 1'b0;
      endcase
    end
  end

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = read_ack && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_flag <= 1'b0;
    end else if (drop) begin
      overflow_flag <= 1'b1;
    end else if (clear_overflow) begin
      overflow_flag <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_count <= '0;
    end else if (scancode_error && error_count != 8'hFF) begin
      error_count <= error_count + 8'd1;
    end
  end

  assign keycode_valid = !empty;
  assign keycode       = keycode_valid ? mem[rd_ptr] : 8'h00;
  assign irq           = keycode_valid && irq_enable;

endmodule

// File: tb/tb_ps2_scancode_queue.sv
// Directed and randomized bench for ps2_scancode_queue against a
// queue-based behavioural model of the prefix and FIFO rules.
module tb_ps2_scancode_queue;

  logic       clock;
  logic       reset;
  logic [7:0] scancode;
  logic       scancode_valid;
  logic       scancode_error;
  logic       read_ack;
  logic       clear_overflow;
  logic       irq_enable;
  logic [7:0] keycode;
  logic       keycode_valid;
  logic       irq;
  logic       overflow_flag;
  logic [7:0] error_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_q[$];
  bit         m_brk;
  bit         m_ovf;
  logic [7:0] m_err;

  ps2_scancode_queue #(.DEPTH_LOG2(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .scancode_error (scancode_error),
    .read_ack       (read_ack),
    .clear_overflow (clear_overflow),
    .irq_enable     (irq_enable),
    .keycode        (keycode),
    .keycode_valid  (keycode_valid),
    .irq            (irq),
    .overflow_flag  (overflow_flag),
    .error_count    (error_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit nonempty;
    nonempty = (m_q.size() != 0);
    chk({tag, ".kv"}, {7'd0, keycode_valid}, {7'd0, nonempty});
    chk({tag, ".irq"}, {7'd0, irq},
        {7'd0, nonempty && irq_enable});
    chk({tag, ".ovf"}, {7'd0, overflow_flag}, {7'd0, m_ovf});
    chk({tag, ".errcnt"}, error_count, m_err);
    if (nonempty) chk({tag, ".keycode"}, keycode, m_q[0]);
  endtask

  // Model: apply one clock edge worth of inputs to the abstract state
  task automatic model_edge(input logic v, input logic [7:0] b,
                            input logic e, input logic a,
                            input logic c);
    bit         do_push;
    logic [7:0] val;
    bit         was_full;
    bit         pop_ok;
    bit         new_ovf;
    do_push  = 0;
    val      = b;
    new_ovf  = 0;
    was_full = (m_q.size() == 8);
    pop_ok   = a && (m_q.size() != 0);
    if (e) begin
      m_brk = 0;
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else if (v) begin
      if (!m_brk) begin
        if (b == 8'hF0) m_brk = 1;
        else do_push = 1;
      end else if (b == 8'hE0) begin
        do_push = 1;
      end else if (b != 8'hF0) begin
        do_push = 1;
        val     = b | 8'h80;
        m_brk   = 0;
      end
    end
    if (pop_ok) void'(m_q.pop_front());
    if (do_push) begin
      if (!was_full || pop_ok) m_q.push_back(val);
      else new_ovf = 1;
    end
    if (new_ovf) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic step(input logic v, input logic [7:0] b,
                      input logic e, input logic a,
                      input logic c, input string tag);
    @(negedge clock);
    scancode_valid = v;
    scancode       = b;
    scancode_error = e;
    read_ack       = a;
    clear_overflow = c;
    @(posedge clock);
    model_edge(v, b, e, a, c);
    #1;
    check_outputs(tag);
    scancode_valid = 1'b0;
    scancode_error = 1'b0;
    read_ack       = 1'b0;
    clear_overflow = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    step(1'b1, b, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string tag);
    chk({tag, ".head"}, keycode, exp);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    #1;
    m_q.delete();
    m_brk = 0;
    m_ovf = 0;
    m_err = 8'h00;
    check_outputs(tag);
    chk({tag, ".keycode0"}, keycode, 8'h00);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int r;
    reset          = 1'b1;
    scancode       = 8'h00;
    scancode_valid = 1'b0;
    scancode_error = 1'b0;
    read_ack       = 1'b0;
    clear_overflow = 1'b0;
    irq_enable     = 1'b1;
    m_brk = 0;
    m_ovf = 0;
    m_err = 8'h00;
    #3;
    check_outputs("reset0");
    chk("reset0.keycode0", keycode, 8'h00);
    @(negedge clock);
    reset = 1'b0;

    // make and break of 0x1C
    send(8'h1C, "make1c");
    chk("make1c.kv_rise", {7'd0, keycode_valid}, 8'd1);
    send(8'hF0, "f0");
    send(8'h1C, "brk1c");
    pop_expect(8'h1C, "pop1c");
    pop_expect(8'h9C, "pop9c");

    // extended break: E0 F0 75
    send(8'hE0, "e0");
    send(8'hF0, "e0f0");
    send(8'h75, "e0f075");
    pop_expect(8'hE0, "pope0");
    pop_expect(8'hF5, "popf5");
    send(8'h2A, "idle_again");
    pop_expect(8'h2A, "pop2a");

    // error aborts a pending break
    send(8'hF0, "f0_err");
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "err1");
    send(8'h1C, "after_err");
    chk("after_err.errcnt1", error_count, 8'h01);
    pop_expect(8'h1C, "pop_after_err");
    chk("after_err.empty", {7'd0, keycode_valid}, 8'd0);

    // overflow with 9 pushes
    for (int i = 1; i <= 9; i++) send(8'(i), "fill9");
    chk("ovf9.flag", {7'd0, overflow_flag}, 8'd1);
    for (int i = 1; i <= 8; i++) pop_expect(8'(i), "drain8");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr_ovf");
    chk("clr_ovf.flag", {7'd0, overflow_flag}, 8'd0);

    // push+ack at full, ack at empty
    for (int i = 0; i < 8; i++) send(8'h40 + 8'(i), "fill8");
    step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, "full_pushpop");
    chk("full_pushpop.noovf", {7'd0, overflow_flag}, 8'd0);
    for (int i = 1; i < 8; i++) pop_expect(8'h40 + 8'(i), "drain_pp");
    pop_expect(8'h55, "drain_pp_last");
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "ack_empty");
    send(8'h33, "after_empty_ack");
    chk("after_empty_ack.kv", {7'd0, keycode_valid}, 8'd1);
    pop_expect(8'h33, "pop33");

    // reset mid-sequence
    for (int i = 0; i < 3; i++) send(8'h10 + 8'(i), "preq");
    send(8'hF0, "pre_reset_f0");
    do_reset("midreset");
    send(8'h1C, "post_reset");
    pop_expect(8'h1C, "post_reset_pop");

    // error saturation
    for (int i = 0; i < 300; i++)
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "errsat");
    chk("errsat.ff", error_count, 8'hFF);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 10 == 0) irq_enable = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 2) b = 8'hF0;
      else if (r == 2) b = 8'hE0;
      else b = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 1)), b,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_queue.md
PS2_SCANCODE_QUEUE -- requirements
Module: ps2_scancode_queue

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 3, meaning the FIFO holds 2**DEPTH_LOG2 entries (8 by default).
REQ-002 The block SHALL have port clock, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port scancode, input, 8, received byte from the PS/2 receive stage; sampled only when scancode_valid=1.
REQ-005 The block SHALL have port scancode_valid, input, 1, one-cycle pulse marking a good byte on scancode.
REQ-006 The block SHALL have port scancode_error, input, 1, one-cycle pulse marking a parity, stop-bit or timeout error.
REQ-007 The block SHALL have port read_ack, input, 1, one-cycle pulse from the consumer popping the head entry.
REQ-008 The block SHALL have port clear_overflow, input, 1, one-cycle pulse clearing overflow_flag.
REQ-009 The block SHALL have port irq_enable, input, 1, level gate for irq.
REQ-010 The block SHALL have port keycode, output, 8, FIFO head entry; value when empty is don't-care.
REQ-011 The block SHALL have port keycode_valid, output, 1, high while the FIFO is non-empty.
REQ-012 The block SHALL have port irq, output, 1, equal to keycode_valid AND irq_enable.
REQ-013 The block SHALL have port overflow_flag, output, 1, sticky flag set when a byte is dropped because the FIFO is full.
REQ-014 The block SHALL have port error_count, output, 8, saturating count of scancode_error pulses.

Function
REQ-015 The block SHALL implement a prefix FSM with states IDLE and BREAK_PENDING.
REQ-016 In IDLE, scancode_valid with byte 0xF0 SHALL move the FSM to BREAK_PENDING with no push.
REQ-017 In IDLE, scancode_valid with any other byte SHALL push that byte unchanged; the FSM stays in IDLE.
REQ-018 In BREAK_PENDING, scancode_valid with byte 0xF0 SHALL leave the FSM in BREAK_PENDING with no push.
REQ-019 In BREAK_PENDING, scancode_valid with byte 0xE0 SHALL push 0xE0 and leave the FSM in BREAK_PENDING.
REQ-020 In BREAK_PENDING, scancode_valid with any other byte b SHALL push (b OR 0x80) and return the FSM to IDLE.
REQ-021 scancode_error SHALL force the FSM to IDLE, push nothing, and increment error_count, saturating at 0xFF.
REQ-022 When scancode_valid and scancode_error are high in the same cycle, the error SHALL take priority and the byte SHALL be ignored.
REQ-023 The FIFO SHALL be a circular buffer with DEPTH_LOG2-bit read and write pointers wrapping modulo depth, plus a (DEPTH_LOG2+1)-bit occupancy count.
REQ-024 A push while count=depth SHALL be discarded and SHALL set overflow_flag; pointers and count SHALL be unchanged, and the FSM transition still occurs.
REQ-025 read_ack while count=0 SHALL be ignored.
REQ-026 Simultaneous push and read_ack while full SHALL accept both, leaving count at depth, with no overflow.
REQ-027 Simultaneous push and read_ack while empty SHALL accept the push only, leaving count at 1.
REQ-028 Simultaneous push and read_ack at any other occupancy SHALL accept both, leaving count unchanged.
REQ-029 Latency: a push accepted at edge N SHALL give keycode_valid=1 and keycode valid after edge N when the FIFO was empty; no combinational path SHALL run from scancode to keycode.
REQ-030 read_ack at edge N SHALL present the next entry on keycode after edge N.
REQ-031 overflow_flag SHALL clear on clear_overflow.
REQ-032 When clear_overflow coincides with a new overflow, set SHALL win.

Reset
REQ-033 Asserting reset SHALL immediately give FSM=IDLE, pointers=0, count=0, keycode_valid=0, irq=0, overflow_flag=0, error_count=0x00, keycode=0x00, including mid-sequence such as after an F0 has been received.
REQ-034 After reset, the first byte SHALL be treated as non-prefixed.

Verification
REQ-035 The bench SHALL drive bytes 0x1C, then F0 and 0x1C -> pops 0x1C then 0x9C; keycode_valid rises one cycle after the first pulse.
REQ-036 The bench SHALL drive E0, F0, 0x75 -> pops 0xE0 then 0xF5; FSM returns to IDLE.
REQ-037 The bench SHALL drive F0, then a scancode_error pulse, then 0x1C -> pops 0x1C only; error_count=1.
REQ-038 The bench SHALL push 9 bytes (0x01..0x09) with no reads -> overflow_flag=1; pops 0x01..0x08; clear_overflow clears the flag.
REQ-039 The bench SHALL apply push and read_ack in the same cycle at count=8, then read_ack at count=0 -> count stays 8 with no overflow; count stays 0.
REQ-040 The bench SHALL assert reset after F0 and 3 queued bytes, then drive 0x1C -> all outputs return to reset values; 0x1C pops as 0x1C.
REQ-041 The bench SHALL apply 300 scancode_error pulses -> error_count=0xFF; irq follows irq_enable whenever keycode_valid=1.
